// File: rtl/wb_commit_arbiter_if.sv
// Writeback/commit bus for wb_commit_arbiter: issue-table writes, per-unit
// writeback results with one-hot acks, the commit packet and the flush suppress.
interface wb_commit_arbiter_if #(
  parameter int NUM_UNITS = 4,
  parameter int MAX_IDS   = 8,
  parameter int PHYS_W    = 6,
  parameter int ID_W      = $clog2(MAX_IDS)
);
  logic                      issue_valid;
  logic [ID_W-1:0]           issue_id;
  logic [PHYS_W-1:0]         issue_phys_addr;
  logic                      issue_uses_rd;
  logic [NUM_UNITS-1:0]      unit_valid;
  logic [NUM_UNITS*ID_W-1:0] unit_id;
  logic [NUM_UNITS*32-1:0]   unit_data;
  logic [NUM_UNITS-1:0]      unit_ack;
  logic                      writeback_supress;
  logic                      commit_valid;
  logic [ID_W-1:0]           commit_id;
  logic [PHYS_W-1:0]         commit_phys_addr;
  logic [31:0]               commit_data;

  modport slave (
    input  issue_valid, issue_id, issue_phys_addr, issue_uses_rd,
    input  unit_valid, unit_id, unit_data, writeback_supress,
    output unit_ack, commit_valid, commit_id, commit_phys_addr, commit_data
  );

  modport master (
    output issue_valid, issue_id, issue_phys_addr, issue_uses_rd,
    output unit_valid, unit_id, unit_data, writeback_supress,
    input  unit_ack, commit_valid, commit_id, commit_phys_addr, commit_data
  );
endinterface

// File: rtl/wb_commit_arbiter.sv
// Round-robin writeback arbiter with an issue-time id->phys table and a registered
// commit packet. Define WB_COMMIT_STATS_EN to add saturating commit/conflict counters.
module wb_commit_arbiter #(
  parameter int NUM_UNITS = 4,
  parameter int MAX_IDS   = 8,
  parameter int ID_W      = $clog2(MAX_IDS),
  parameter int PHYS_W    = 6
) (
  input  logic clk,
  input  logic rst,
  wb_commit_arbiter_if.slave bus
`ifdef WB_COMMIT_STATS_EN
  ,
  output logic [31:0] stat_commits,
  output logic [31:0] stat_conflicts
`endif
);

  localparam int PTR_W  = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int DATA_W = 32;

  logic [PTR_W-1:0]  ptr_r;
  logic              tab_uses_r [MAX_IDS];
  logic [PHYS_W-1:0] tab_phys_r [MAX_IDS];
  logic              commit_valid_r;
  logic [ID_W-1:0]   commit_id_r;
  logic [PHYS_W-1:0] commit_phys_r;
  logic [DATA_W-1:0] commit_data_r;

  logic                 grant_found_s;
  logic [PTR_W-1:0]     grant_idx_s;
  logic [PTR_W-1:0]     next_ptr_s;
  logic [ID_W-1:0]      grant_id_s;
  logic [DATA_W-1:0]    grant_data_s;
  logic                 bypass_s;
  logic                 sel_uses_s;
  logic [PHYS_W-1:0]    sel_phys_s;
  logic [NUM_UNITS-1:0] ack_s;

  function automatic logic [PTR_W-1:0] scan_idx(input logic [PTR_W-1:0] base, input int off);
    int sum_v;
    sum_v = int'(base) + off;
    if (sum_v >= NUM_UNITS) begin
      sum_v = sum_v - NUM_UNITS;
    end
    return PTR_W'(sum_v);
  endfunction

  // Round-robin scan: first valid unit at or after the pointer wins.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (!grant_found_s && bus.unit_valid[scan_idx(ptr_r, k)]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = scan_idx(ptr_r, k);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Winner payload, table lookup with same-cycle issue bypass, ack and next pointer.
  always_comb begin
    grant_id_s   = bus.unit_id[grant_idx_s*ID_W +: ID_W];
    grant_data_s = bus.unit_data[grant_idx_s*DATA_W +: DATA_W];
    bypass_s     = bus.issue_valid && (bus.issue_id == grant_id_s);
    if (bypass_s) begin
      sel_uses_s = bus.issue_uses_rd;
      sel_phys_s = bus.issue_phys_addr;
    end else begin
      sel_uses_s = tab_uses_r[grant_id_s];
      sel_phys_s = tab_phys_r[grant_id_s];
    end
    if (grant_idx_s == PTR_W'(NUM_UNITS - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = grant_idx_s + PTR_W'(1);
    end
    ack_s = '0;
    if (grant_found_s && !rst) begin
      ack_s[grant_idx_s] = 1'b1;
    end else begin
      ack_s = '0;
    end
  end

  // Issue table: written at issue, only cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_IDS; i++) begin
        tab_uses_r[i] <= 1'b0;
        tab_phys_r[i] <= '0;
      end
    end else if (bus.issue_valid) begin
      tab_uses_r[bus.issue_id] <= bus.issue_uses_rd;
      tab_phys_r[bus.issue_id] <= bus.issue_phys_addr;
    end
  end

  // Pointer advance and commit register; fields hold when nobody wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r          <= '0;
      commit_valid_r <= 1'b0;
      commit_id_r    <= '0;
      commit_phys_r  <= '0;
      commit_data_r  <= '0;
    end else if (grant_found_s) begin
      ptr_r          <= next_ptr_s;
      commit_valid_r <= sel_uses_s & ~bus.writeback_supress;
      commit_id_r    <= grant_id_s;
      commit_phys_r  <= sel_phys_s;
      commit_data_r  <= grant_data_s;
    end else begin
      commit_valid_r <= 1'b0;
    end
  end

  assign bus.unit_ack         = ack_s;
  assign bus.commit_valid     = commit_valid_r;
  assign bus.commit_id        = commit_id_r;
  assign bus.commit_phys_addr = commit_phys_r;
  assign bus.commit_data      = commit_data_r;

`ifdef WB_COMMIT_STATS_EN
  logic [31:0] stat_commits_r;
  logic [31:0] stat_conflicts_r;

  // Saturating activity counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_commits_r   <= 32'd0;
      stat_conflicts_r <= 32'd0;
    end else begin
      if (commit_valid_r && (stat_commits_r != 32'hFFFF_FFFF)) begin
        stat_commits_r <= stat_commits_r + 32'd1;
      end
      if (($countones(bus.unit_valid) > 1) && (stat_conflicts_r != 32'hFFFF_FFFF)) begin
        stat_conflicts_r <= stat_conflicts_r + 32'd1;
      end
    end
  end

  assign stat_commits   = stat_commits_r;
  assign stat_conflicts = stat_conflicts_r;
`endif

endmodule

// File: tb/tb_wb_commit_arbiter.sv
// Self-checking bench for wb_commit_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level model of the arbiter.
module tb_wb_commit_arbiter;
  localparam int N       = 4;
  localparam int MAX_IDS = 8;
  localparam int ID_W    = 3;
  localparam int PHYS_W  = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_commit_arbiter_if #(.NUM_UNITS(N), .MAX_IDS(MAX_IDS), .PHYS_W(PHYS_W)) bus();
`ifdef WB_COMMIT_STATS_EN
  logic [31:0] stat_commits, stat_conflicts;
`endif

  wb_commit_arbiter #(.NUM_UNITS(N), .MAX_IDS(MAX_IDS), .ID_W(ID_W), .PHYS_W(PHYS_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef WB_COMMIT_STATS_EN
    ,
    .stat_commits(stat_commits),
    .stat_conflicts(stat_conflicts)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  int              m_ptr;
  bit              m_uses [MAX_IDS];
  logic [PHYS_W-1:0] m_phys [MAX_IDS];
  bit              m_cv;
  logic [ID_W-1:0] m_cid;
  logic [PHYS_W-1:0] m_cphys;
  logic [31:0]     m_cdata;
  longint          m_commits;
  longint          m_conf;

  task automatic clear_inputs();
    bus.issue_valid = 1'b0; bus.issue_id = '0; bus.issue_phys_addr = '0; bus.issue_uses_rd = 1'b0;
    bus.unit_valid = '0; bus.unit_id = '0; bus.unit_data = '0; bus.writeback_supress = 1'b0;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_cv = 0; m_cid = '0; m_cphys = '0; m_cdata = '0; m_commits = 0; m_conf = 0;
    for (int i = 0; i < MAX_IDS; i++) begin m_uses[i] = 0; m_phys[i] = '0; end
  endtask

  function automatic int m_winner();
    for (int k = 0; k < N; k++) begin
      if (bus.unit_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ack();
    int w;
    logic [N-1:0] one;
    w = m_winner();
    one = 1;
    if (w < 0) return '0;
    return one << w;
  endfunction

  task automatic set_issue(input bit v, input int id, input int phys, input bit uses);
    bus.issue_valid = v; bus.issue_id = ID_W'(id); bus.issue_phys_addr = PHYS_W'(phys); bus.issue_uses_rd = uses;
  endtask

  task automatic set_unit(input int u, input bit v, input int id, input logic [31:0] data);
    bus.unit_valid[u] = v; bus.unit_id[u*ID_W +: ID_W] = ID_W'(id); bus.unit_data[u*32 +: 32] = data;
  endtask

  // Advance one clock, applying the specification's rules to the model.
  task automatic tick();
    int w;
    logic [ID_W-1:0] wid;
    w = m_winner();
    @(posedge clk);
    if (m_cv && m_commits < 64'hFFFF_FFFF) m_commits++;
    if ($countones(bus.unit_valid) > 1 && m_conf < 64'hFFFF_FFFF) m_conf++;
    if (w >= 0) begin
      wid = bus.unit_id[w*ID_W +: ID_W];
      m_cid = wid;
      m_cdata = bus.unit_data[w*32 +: 32];
      if (bus.issue_valid && bus.issue_id == wid) begin
        m_cv = bus.issue_uses_rd && !bus.writeback_supress; m_cphys = bus.issue_phys_addr;
      end else begin
        m_cv = m_uses[wid] && !bus.writeback_supress; m_cphys = m_phys[wid];
      end
      m_ptr = (w + 1) % N;
    end else begin
      m_cv = 0;
    end
    if (bus.issue_valid) begin m_uses[bus.issue_id] = bus.issue_uses_rd; m_phys[bus.issue_id] = bus.issue_phys_addr; end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1; clear_inputs(); model_reset();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear_inputs(); model_reset();
    bus.unit_valid = '1;
    @(negedge clk); @(negedge clk); #1;
    checks++; if (bus.commit_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.commit_valid); end
    checks++; if (bus.commit_id !== '0) begin errors++; $display("FAIL reset_id got=%0d exp=0", bus.commit_id); end
    checks++; if (bus.commit_phys_addr !== '0) begin errors++; $display("FAIL reset_phys got=%h exp=0", bus.commit_phys_addr); end
    checks++; if (bus.commit_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", bus.commit_data); end
    checks++; if (bus.unit_ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got=%b exp=0000", bus.unit_ack); end
    @(negedge clk);
    rst = 1'b0; clear_inputs();
  endtask

  task automatic test_basic_commit();
    set_issue(1, 3, 6'h15, 1); tick();
    set_issue(0, 0, 0, 0);
    set_unit(1, 1, 3, 32'hDEADBEEF); #1;
    checks++; if (bus.unit_ack !== 4'b0010) begin errors++; $display("FAIL basic_ack got=%b exp=0010", bus.unit_ack); end
    tick();
    checks++; if (bus.commit_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", bus.commit_valid); end
    checks++; if (bus.commit_id !== 3'd3) begin errors++; $display("FAIL basic_id got=%0d exp=3", bus.commit_id); end
    checks++; if (bus.commit_phys_addr !== 6'h15) begin errors++; $display("FAIL basic_phys got=%h exp=15", bus.commit_phys_addr); end
    checks++; if (bus.commit_data !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_data got=%h exp=deadbeef", bus.commit_data); end
    clear_inputs(); tick();
    checks++; if (bus.commit_valid !== 1'b0) begin errors++; $display("FAIL basic_idle_valid got=%b exp=0", bus.commit_valid); end
    checks++; if (bus.commit_data !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_hold_data got=%h exp=deadbeef", bus.commit_data); end
  endtask

  task automatic test_round_robin();
    logic [3:0] seq [5];
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
    apply_reset();
    for (int u = 0; u < N; u++) set_unit(u, 1, u, 32'h100 + u);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (bus.unit_ack !== seq[i]) begin errors++; $display("FAIL rr_ack%0d got=%b exp=%b", i, bus.unit_ack, seq[i]); end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_no_rd();
    set_issue(1, 5, 6'h11, 0); tick();
    set_issue(0, 0, 0, 0);
    set_unit(2, 1, 5, 32'h55AA55AA); #1;
    checks++; if (bus.unit_ack !== 4'b0100) begin errors++; $display("FAIL nord_ack got=%b exp=0100", bus.unit_ack); end
    tick();
    checks++; if (bus.commit_valid !== 1'b0) begin errors++; $display("FAIL nord_valid got=%b exp=0", bus.commit_valid); end
    clear_inputs();
  endtask

  task automatic test_suppress();
    set_issue(1, 2, 6'h0C, 1); tick();
    set_issue(1, 4, 6'h07, 1); tick();
    set_issue(0, 0, 0, 0);
    bus.writeback_supress = 1'b1;
    set_unit(0, 1, 2, 32'h12345678); #1;
    checks++; if (bus.unit_ack !== 4'b0001) begin errors++; $display("FAIL supp_ack got=%b exp=0001", bus.unit_ack); end
    tick();
    checks++; if (bus.commit_valid !== 1'b0) begin errors++; $display("FAIL supp_valid got=%b exp=0", bus.commit_valid); end
    bus.writeback_supress = 1'b0;
    set_unit(0, 1, 4, 32'h87654321); tick();
    checks++; if (bus.commit_valid !== 1'b1) begin errors++; $display("FAIL supp_release_valid got=%b exp=1", bus.commit_valid); end
    checks++; if (bus.commit_phys_addr !== 6'h07) begin errors++; $display("FAIL supp_release_phys got=%h exp=07", bus.commit_phys_addr); end
    clear_inputs();
  endtask

  task automatic test_bypass();
    set_issue(1, 6, 6'h01, 1); tick();
    set_issue(1, 6, 6'h2A, 1);
    set_unit(3, 1, 6, 32'hCAFEF00D); #1;
    checks++; if (bus.unit_ack !== 4'b1000) begin errors++; $display("FAIL byp_ack got=%b exp=1000", bus.unit_ack); end
    tick();
    checks++; if (bus.commit_valid !== 1'b1) begin errors++; $display("FAIL byp_valid got=%b exp=1", bus.commit_valid); end
    checks++; if (bus.commit_phys_addr !== 6'h2A) begin errors++; $display("FAIL byp_phys got=%h exp=2a", bus.commit_phys_addr); end
    clear_inputs();
  endtask

  task automatic test_random();
    int w;
    for (int c = 0; c < 1500; c++) begin
      set_issue(($urandom_range(0, 2) == 0), $urandom_range(0, MAX_IDS-1), $urandom_range(0, 63), $urandom_range(0, 3) != 0);
      bus.writeback_supress = ($urandom_range(0, 9) == 0);
      #1;
      checks++; if (bus.unit_ack !== exp_ack()) begin errors++; $display("FAIL rand_ack c=%0d got=%b exp=%b", c, bus.unit_ack, exp_ack()); end
      w = m_winner();
      tick();
      checks++;
      if (bus.commit_valid !== m_cv || bus.commit_id !== m_cid || bus.commit_phys_addr !== m_cphys || bus.commit_data !== m_cdata) begin
        errors++;
        $display("FAIL rand_commit c=%0d got=%b/%0d/%h/%h exp=%b/%0d/%h/%h", c, bus.commit_valid, bus.commit_id,
                 bus.commit_phys_addr, bus.commit_data, m_cv, m_cid, m_cphys, m_cdata);
      end
      // Units hold until acked; an acked or idle unit may present something new.
      for (int u = 0; u < N; u++) begin
        if (u == w || !bus.unit_valid[u]) set_unit(u, ($urandom_range(0, 9) < 6), $urandom_range(0, MAX_IDS-1), $urandom());
      end
    end
    clear_inputs(); tick();
`ifdef WB_COMMIT_STATS_EN
    checks++; if (stat_commits !== 32'(m_commits)) begin errors++; $display("FAIL stat_commits got=%0d exp=%0d", stat_commits, m_commits); end
    checks++; if (stat_conflicts !== 32'(m_conf)) begin errors++; $display("FAIL stat_conflicts got=%0d exp=%0d", stat_conflicts, m_conf); end
`endif
  endtask

  task automatic test_reset_midop();
    set_issue(1, 1, 6'h33, 1); tick();
    set_issue(0, 0, 0, 0);
    set_unit(2, 1, 1, 32'hA5A5A5A5); tick();
    checks++; if (bus.commit_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid got=%b exp=1", bus.commit_valid); end
    #2 rst = 1'b1; model_reset();
    #1;
    checks++; if (bus.commit_valid !== 1'b0 || bus.commit_id !== '0 || bus.commit_phys_addr !== '0 || bus.commit_data !== 32'h0)
      begin errors++; $display("FAIL midrst_outputs got=%b/%0d/%h/%h exp=0/0/0/0", bus.commit_valid, bus.commit_id, bus.commit_phys_addr, bus.commit_data); end
    checks++; if (bus.unit_ack !== 4'b0000) begin errors++; $display("FAIL midrst_ack got=%b exp=0000", bus.unit_ack); end
    @(negedge clk);
    rst = 1'b0; bus.unit_valid = '1; #1;
    checks++; if (bus.unit_ack !== 4'b0001) begin errors++; $display("FAIL midrst_first_grant got=%b exp=0001", bus.unit_ack); end
    tick();
    checks++; if (bus.commit_valid !== 1'b0) begin errors++; $display("FAIL midrst_table_cleared got=%b exp=0", bus.commit_valid); end
    clear_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_commit();
    test_round_robin();
    test_no_rd();
    test_suppress();
    test_bypass();
    test_random();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
